// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: steps fetch/decode/exec/mem/wb around variable-latency
// memories, with a sticky halt and a memory-wait timeout that parks the block in ERROR.
module multicycle_control_unit #(
  parameter int unsigned TIMEOUT = 200,
  parameter int unsigned WAIT_W  = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] instr,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        zero,
  output logic        iREN,
  output logic        dREN,
  output logic        dWEN,
  output logic        ir_en,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_srcb,
  output logic        extop,
  output logic        regwr,
  output logic [1:0]  regdst,
  output logic [1:0]  memtoreg,
  output logic        halt,
  output logic        timeout_err,
  output logic [2:0]  state
);
  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
                         ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                         ALU_SLT = 4'd10, ALU_SLTU = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B, OP_HALT = 6'h3F;

  localparam logic [WAIT_W-1:0] WLIM = (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_HALTED = 3'd5, S_ERROR = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;

  logic [5:0] op, funct;
  logic       unused_instr;
  assign op           = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[25:6];

  // Hits are masked while reset is held so no load pulse escapes during reset.
  logic ihit_v, dhit_v, tmo;
  assign ihit_v = ihit & nRST;
  assign dhit_v = dhit & nRST;
  assign tmo    = (TIMEOUT != 0) && (wcnt_q == WLIM);

  logic [3:0] d_alu;
  logic [1:0] d_srcb;
  logic       d_ext, d_r, d_jr, d_ok;

  always_comb begin
    d_alu = ALU_ADD; d_srcb = 2'd0; d_ext = 1'b0;
    d_r = 1'b0; d_jr = 1'b0; d_ok = 1'b1;
    case (op)
      OP_RTYPE: begin
        d_r = 1'b1;
        case (funct)
          6'h20, 6'h21: d_alu = ALU_ADD;
          6'h22, 6'h23: d_alu = ALU_SUB;
          6'h24:        d_alu = ALU_AND;
          6'h25:        d_alu = ALU_OR;
          6'h26:        d_alu = ALU_XOR;
          6'h27:        d_alu = ALU_NOR;
          6'h00:        d_alu = ALU_SLL;
          6'h02:        d_alu = ALU_SRL;
          6'h2A:        d_alu = ALU_SLT;
          6'h2B:        d_alu = ALU_SLTU;
          6'h08:        begin d_r = 1'b0; d_jr = 1'b1; end
          default:      begin d_r = 1'b0; d_ok = 1'b0; end
        endcase
      end
      OP_ADDIU:      begin d_alu = ALU_ADD;  d_srcb = 2'd1; d_ext = 1'b1; end
      OP_SLTI:       begin d_alu = ALU_SLT;  d_srcb = 2'd1; d_ext = 1'b1; end
      OP_SLTIU:      begin d_alu = ALU_SLTU; d_srcb = 2'd1; d_ext = 1'b1; end
      OP_ANDI:       begin d_alu = ALU_AND;  d_srcb = 2'd1; end
      OP_ORI:        begin d_alu = ALU_OR;   d_srcb = 2'd1; end
      OP_XORI:       begin d_alu = ALU_XOR;  d_srcb = 2'd1; end
      OP_LUI:        begin d_alu = ALU_OR;   d_srcb = 2'd2; end
      OP_LW, OP_SW:  begin d_alu = ALU_ADD;  d_srcb = 2'd1; d_ext = 1'b1; end
      OP_BEQ, OP_BNE: d_alu = ALU_SUB;
      OP_J, OP_JAL, OP_HALT: ;
      default:       d_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ir_en = 1'b0; pc_en = 1'b0;
    pc_src = 2'd0; alu_op = 4'd0; alu_srcb = 2'd0; extop = 1'b0;
    regwr = 1'b0; regdst = 2'd0; memtoreg = 2'd0; halt = 1'b0; timeout_err = 1'b0;
    case (state_q)
      S_FETCH: begin
        iREN = 1'b1;
        if (ihit_v) begin
          ir_en = 1'b1; pc_en = 1'b1; state_d = S_DECODE;
        end else if (tmo) state_d = S_ERROR;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        if (d_ok) begin
          case (op)
            OP_HALT: state_d = S_HALTED;
            OP_J, OP_JAL: begin
              pc_en = 1'b1; pc_src = 2'd2;
              if (op == OP_JAL) begin regwr = 1'b1; regdst = 2'd2; memtoreg = 2'd2; end
            end
            default:
              if (d_jr) begin pc_en = 1'b1; pc_src = 2'd3; end
              else state_d = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        alu_op = d_alu; alu_srcb = d_srcb; extop = d_ext;
        case (op)
          OP_BEQ:       begin pc_src = 2'd1; pc_en = zero;  state_d = S_FETCH; end
          OP_BNE:       begin pc_src = 2'd1; pc_en = ~zero; state_d = S_FETCH; end
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        alu_op = d_alu; alu_srcb = d_srcb; extop = d_ext;
        dREN = (op == OP_LW);
        dWEN = (op == OP_SW);
        if (dhit_v) state_d = (op == OP_LW) ? S_WB : S_FETCH;
        else if (tmo) state_d = S_ERROR;
      end
      S_WB: begin
        alu_op = d_alu; alu_srcb = d_srcb; extop = d_ext;
        regwr    = 1'b1;
        regdst   = d_r ? 2'd1 : 2'd0;
        memtoreg = (op == OP_LW) ? 2'd1 : 2'd0;
        state_d  = S_FETCH;
      end
      S_HALTED: halt = 1'b1;
      S_ERROR:  timeout_err = 1'b1;
      default:  state_d = S_FETCH;
    endcase
  end

  // Counter restarts on every transition; it only advances while stalled on a miss.
  always_comb begin
    wcnt_d = wcnt_q;
    if (state_d != state_q) wcnt_d = '0;
    else if (((state_q == S_FETCH) && !ihit_v) || ((state_q == S_MEM) && !dhit_v))
      wcnt_d = (&wcnt_q) ? wcnt_q : wcnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_FETCH;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign state = state_q;
endmodule
